// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_arb_pkg
// Purpose  : Shared state type, stat width and round-robin helper for the
//            fifo write arbiter and its picker.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam int STAT_W  = 32;
    localparam int MAX_REQ = 32;
    localparam int MAX_IDX = $clog2(MAX_REQ);

    // First valid index after 'last', wrapping modulo n; returns 'last' when none valid.
    function automatic int rr_next(input int last, input logic [MAX_REQ-1:0] valid, input int n);
        int   cand;
        logic hit;
        rr_next = last;
        hit     = 1'b0;
        for (int i = 1; i <= MAX_REQ; i++) begin
            if (!hit && (i <= n)) begin
                cand = last + i;
                if (cand >= n) begin
                    cand = cand - n;
                end
                if (valid[cand[MAX_IDX-1:0]]) begin
                    rr_next = cand;
                    hit     = 1'b1;
                end
            end
        end
    endfunction

endpackage : fifo_arb_pkg
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin picker: scans from last_idx+1 upward.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0] last_idx_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    logic [MAX_REQ-1:0] valid_ext;
    int                 pick;

    always_comb begin
        valid_ext                = '0;
        valid_ext[N_REQ-1:0]     = valid_i;
        pick                     = rr_next(int'(last_idx_i), valid_ext, N_REQ);
        idx_o                    = IDX_W'(pick);
        found_o                  = |valid_i;
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Round-robin, burst-bounded sharing of one fifo write port between
//            N_REQ producers. Optional stats under FIFO_WR_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DWIDTH    = 32,
    parameter int AWIDTH    = 4,
    parameter int N_REQ     = 4,
    parameter int BURST_LEN = 4
) (
    input  logic                    clk_i,
    input  logic                    arst_n_i,
    input  logic [N_REQ*DWIDTH-1:0] req_data_i,
    input  logic [N_REQ-1:0]        req_valid_i,
    output logic [N_REQ-1:0]        req_ready_o,
    output logic [DWIDTH-1:0]       fifo_data_o,
    output logic                    fifo_wrreq_o,
    input  logic                    fifo_full_i,
    input  logic [AWIDTH:0]         fifo_usedw_i,
    output logic [N_REQ-1:0]        grant_o,
    output logic                    busy_o
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [N_REQ*STAT_W-1:0] stat_beats_o,
    output logic [STAT_W-1:0]       stat_full_cyc_o,
    output logic [AWIDTH:0]         stat_max_usedw_o
`endif
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] last_idx_q, last_idx_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [N_REQ-1:0] grant_q, grant_d;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             transfer;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .valid_i    (req_valid_i),
        .last_idx_i (last_idx_q),
        .idx_o      (pick_idx),
        .found_o    (pick_found)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_idx_d  = last_idx_q;
        beat_cnt_d  = beat_cnt_q;
        grant_d     = grant_q;
        req_ready_o = '0;
        transfer    = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_d    = ARB_GRANT;
                    owner_d    = pick_idx;
                    grant_d    = N_REQ'(1) << pick_idx;
                    beat_cnt_d = '0;
                end
            end
            ARB_GRANT: begin
                // Full stalls the burst without consuming a beat; the grant is kept.
                req_ready_o[owner_q] = !fifo_full_i;
                transfer             = req_valid_i[owner_q] && !fifo_full_i;
                if (transfer) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
                if ((transfer && (beat_cnt_q == LAST_BEAT)) || !req_valid_i[owner_q]) begin
                    state_d    = ARB_IDLE;
                    last_idx_d = owner_q;
                    grant_d    = '0;
                    beat_cnt_d = '0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q    <= ARB_IDLE;
            owner_q    <= '0;
            last_idx_q <= IDX_W'(N_REQ - 1);
            beat_cnt_q <= '0;
            grant_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_idx_q <= last_idx_d;
            beat_cnt_q <= beat_cnt_d;
            grant_q    <= grant_d;
        end
    end

    assign fifo_wrreq_o = transfer;
    assign fifo_data_o  = req_data_i[owner_q*DWIDTH +: DWIDTH];
    assign grant_o      = grant_q;
    assign busy_o       = (state_q == ARB_GRANT);

`ifdef FIFO_WR_ARB_STATS_EN
    logic [N_REQ-1:0][STAT_W-1:0] stat_beats_q, stat_beats_d;
    logic [STAT_W-1:0]            stat_full_cyc_q, stat_full_cyc_d;
    logic [AWIDTH:0]              stat_max_usedw_q, stat_max_usedw_d;

    always_comb begin
        stat_beats_d     = stat_beats_q;
        stat_full_cyc_d  = stat_full_cyc_q;
        stat_max_usedw_d = stat_max_usedw_q;
        if (transfer) begin
            stat_beats_d[owner_q] = stat_beats_q[owner_q] + 1'b1;
        end
        if ((state_q == ARB_GRANT) && fifo_full_i) begin
            stat_full_cyc_d = stat_full_cyc_q + 1'b1;
        end
        if (fifo_usedw_i > stat_max_usedw_q) begin
            stat_max_usedw_d = fifo_usedw_i;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            stat_beats_q     <= '0;
            stat_full_cyc_q  <= '0;
            stat_max_usedw_q <= '0;
        end else begin
            stat_beats_q     <= stat_beats_d;
            stat_full_cyc_q  <= stat_full_cyc_d;
            stat_max_usedw_q <= stat_max_usedw_d;
        end
    end

    assign stat_beats_o     = stat_beats_q;
    assign stat_full_cyc_o  = stat_full_cyc_q;
    assign stat_max_usedw_o = stat_max_usedw_q;
`else
    // usedw only feeds the stats; fold it so it is not left dangling.
    logic unused_usedw;
    assign unused_usedw = ^fifo_usedw_i;
`endif

endmodule : fifo_wr_arbiter
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Purpose  : Scoreboard bench for fifo_wr_arbiter (directed lane traffic).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int N  = 4;
    localparam int BL = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   fifo_data;
    logic            fifo_wrreq;
    logic            fifo_full;
    logic [AW:0]     usedw;
    logic [N-1:0]    grant;
    logic            busy;
    logic            full_force, model_full_en, rd_toggle_en, rd_phase;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [N*32-1:0] stat_beats;
    logic [31:0]     stat_full_cyc;
    logic [AW:0]     stat_max_usedw;
`endif

    always #5 clk = ~clk;

    assign fifo_full = full_force | (model_full_en && (usedw == 5'd16));

    fifo_wr_arbiter #(
        .DWIDTH    (DW),
        .AWIDTH    (AW),
        .N_REQ     (N),
        .BURST_LEN (BL)
    ) dut (
        .clk_i        (clk),
        .arst_n_i     (rst_n),
        .req_data_i   (req_data),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .fifo_data_o  (fifo_data),
        .fifo_wrreq_o (fifo_wrreq),
        .fifo_full_i  (fifo_full),
        .fifo_usedw_i (usedw),
        .grant_o      (grant),
        .busy_o       (busy)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .stat_beats_o     (stat_beats),
        .stat_full_cyc_o  (stat_full_cyc),
        .stat_max_usedw_o (stat_max_usedw)
`endif
    );

    typedef struct packed { logic [1:0] lane; logic [31:0] data;  } wr_t;
    typedef struct packed { logic [1:0] lane; logic [31:0] beats; } burst_t;

    wr_t         exp_wr[$];
    burst_t      exp_burst[$];
    logic [31:0] lane_q[N][$];
    int          pops[N];
    logic [N-1:0] acc;
    logic        wr_seen;
    int          compared = 0;
    int          mismatched = 0;
    int          stall_cnt = 0;
    int          cur_beats = 0;
    int          idle_run = 0;
    int          last_gap = 0;
    logic [AW:0] ref_peak = '0;
    logic [N-1:0] prev_grant = '0;

    function automatic logic [31:0] word(input int k, input int j);
        return 32'hA000_0000 | 32'(k << 8) | 32'(j);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic load(input int k, input int first, input int n);
        for (int j = 0; j < n; j++) lane_q[k].push_back(word(k, first + j));
    endtask

    task automatic push_burst(input int k, input int first, input int n);
        for (int j = 0; j < n; j++) exp_wr.push_back({2'(k), word(k, first + j)});
        exp_burst.push_back({2'(k), 32'(n)});
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((exp_wr.size() != 0 || exp_burst.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        compared++;
        if (exp_wr.size() != 0 || exp_burst.size() != 0) begin
            mismatched++;
            $display("FAIL %s_timeout: %0d writes / %0d bursts outstanding, required 0",
                     name, exp_wr.size(), exp_burst.size());
            exp_wr.delete();
            exp_burst.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic wait_pops(input int k, input int target, input int budget);
        int n = 0;
        while (pops[k] < target && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("wait_pops_bound", 64'(pops[k] >= target), 64'd1);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        for (int k = 0; k < N; k++) begin
            lane_q[k].delete();
            pops[k] = 0;
        end
        full_force    = 1'b0;
        model_full_en = 1'b0;
        rd_toggle_en  = 1'b0;
        usedw         = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Producer lanes and a simple fifo occupancy model.
    initial begin
        req_valid = '0;
        req_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                if (acc[k]) begin
                    void'(lane_q[k].pop_front());
                    pops[k]++;
                end
            end
            begin
                logic [AW:0] nxt;
                logic        rd;
                nxt = usedw;
                rd  = rd_toggle_en ? rd_phase : 1'b1;
                if (wr_seen) nxt = nxt + 1'b1;
                if (rd && (usedw != 0)) nxt = nxt - 1'b1;
                usedw    = nxt;
                rd_phase = ~rd_phase;
            end
            acc     = '0;
            wr_seen = 1'b0;
            for (int k = 0; k < N; k++) begin
                req_valid[k]          = (lane_q[k].size() > 0);
                req_data[k*DW +: DW]  = (lane_q[k].size() > 0) ? lane_q[k][0] : 32'h0;
            end
        end
    end

    // Monitor: scoreboard pops on every fifo write and burst end.
    always @(negedge clk) begin
        acc     = req_valid & req_ready;
        wr_seen = fifo_wrreq;
        if (rst_n) begin
            if (busy) check("grant_onehot", 64'($onehot(grant)), 64'd1);
            else      check("idle_grant", 64'(grant), 64'd0);
            check("ready", 64'(req_ready), 64'((busy && !fifo_full) ? grant : 4'b0));
            if (fifo_full) check("wrreq_full", 64'(fifo_wrreq), 64'd0);
            if (busy && fifo_full) stall_cnt++;
            if (usedw > ref_peak) ref_peak = usedw;
            if (grant == '0) idle_run++;
            else begin
                if (prev_grant == '0) last_gap = idle_run;
                idle_run = 0;
            end
        end
        if (grant !== prev_grant) begin
            if (prev_grant != '0) begin
                check("bubble", 64'(grant), 64'd0);
                if (exp_burst.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_burst: lane mask %0h beats %0d, required none", prev_grant, cur_beats);
                end else begin
                    burst_t b;
                    b = exp_burst.pop_front();
                    check("burst_lane", 64'(prev_grant), 64'(4'b1 << b.lane));
                    check("burst_beats", 64'(cur_beats), 64'(b.beats));
                end
            end
            cur_beats = 0;
        end
        prev_grant = grant;
        if (fifo_wrreq) begin
            cur_beats++;
            if (exp_wr.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_write: data %0h, required no write", fifo_data);
            end else begin
                wr_t e;
                e = exp_wr.pop_front();
                check("wr_data", 64'(fifo_data), 64'(e.data));
                check("wr_grant", 64'(grant), 64'(4'b1 << e.lane));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; full_force = 1'b0; model_full_en = 1'b0;
        rd_toggle_en = 1'b0; rd_phase = 1'b0; usedw = '0;
        acc = '0; wr_seen = 1'b0;
        for (int k = 0; k < N; k++) pops[k] = 0;
        #3;
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_wrreq", 64'(fifo_wrreq), 64'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Single lane: bursts of 4/4/2 separated by bubbles.
        load(0, 0, 10);
        push_burst(0, 0, 4); push_burst(0, 4, 4); push_burst(0, 8, 2);
        drain("t1", 200);

        // All lanes busy: rotation 0,1,2,3,0,...
        do_reset();
        for (int k = 0; k < N; k++) load(k, 0, 8);
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < N; k++) push_burst(k, 4 * r, 4);
        drain("t2", 300);

        // Full for five cycles after lane 2's first beat.
        do_reset();
        load(2, 0, 6);
        push_burst(2, 0, 4); push_burst(2, 4, 2);
        wait_pops(2, 1, 50);
        stall_cnt  = 0;
        full_force = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        check("t3_no_pop_while_full", 64'(pops[2]), 64'd1);
        full_force = 1'b0;
        drain("t3", 200);
        check("t3_stall_cycles", 64'(stall_cnt), 64'd5);

        // Lane 1 runs dry after 2 beats; lane 3 follows after one idle cycle.
        do_reset();
        load(1, 0, 2); load(3, 0, 4);
        push_burst(1, 0, 2); push_burst(3, 0, 4);
        drain("t4", 200);
        check("t4_idle_gap", 64'(last_gap), 64'd1);

        // Reset in the middle of a burst.
        do_reset();
        load(2, 0, 8);
        push_burst(2, 0, 2);
        wait_pops(2, 2, 50);
        rst_n = 1'b0;
        #1;
        check("t5_async_grant", 64'(grant), 64'd0);
        check("t5_async_busy", 64'(busy), 64'd0);
        check("t5_async_ready", 64'(req_ready), 64'd0);
        check("t5_async_wrreq", 64'(fifo_wrreq), 64'd0);
        load(0, 0, 4);
        push_burst(0, 0, 4); push_burst(2, 2, 4); push_burst(2, 6, 2);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        drain("t5", 300);

`ifdef FIFO_WR_ARB_STATS_EN
        do_reset();
        rd_toggle_en  = 1'b1;
        model_full_en = 1'b1;
        ref_peak      = '0;
        for (int k = 0; k < N; k++) load(k, 0, 10);
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < N; k++) push_burst(k, 4 * r, (r < 2) ? 4 : 2);
        drain("t6", 600);
        repeat (2) @(posedge clk);
        #2;
        for (int k = 0; k < N; k++) check("t6_stat_beats", 64'(stat_beats[k*32 +: 32]), 64'd10);
        check("t6_stat_max_usedw", 64'(stat_max_usedw), 64'(ref_peak));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_fifo_wr_arbiter
`default_nettype wire
